// File: rtl/sm4_encryptor_pkg.sv
// Shared constants for the SM4 encryptor key cache.
package sm4_encryptor_pkg;

    localparam int cache_ways_c  = 4;
    localparam int cache_idx_w_c = $clog2(cache_ways_c);

endpackage

// File: rtl/priority_encoder.sv
// Lowest-index-wins priority encoder with a valid flag.
module priority_encoder #(
    parameter int width_p = 4,
    localparam int out_w_lp = $clog2(width_p)
) (
    input  logic [width_p-1:0]  i,
    output logic [out_w_lp-1:0] o,
    output logic                v_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        o   = '0;
        v_o = |i;
        for (int k = width_p - 1; k >= 0; k--) begin
            if (i[k]) begin
                o = out_w_lp'(k);
            end
        end
    end

endmodule

// File: rtl/cache_lru_recorder.sv
// True-LRU recency stack for the key cache, plus hit-vector encoding.
module cache_lru_recorder
    import sm4_encryptor_pkg::*;
#(
    parameter int ways_p = cache_ways_c,
    localparam int idx_w_lp = $clog2(ways_p)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [idx_w_lp-1:0] access1_i,
    input  logic                v1_i,
    input  logic [idx_w_lp-1:0] access2_i,
    input  logic                v2_i,
    output logic [idx_w_lp-1:0] replace_which_o,
    input  logic [ways_p-1:0]   hit_i,
    output logic [idx_w_lp-1:0] hit_idx_o,
    output logic                any_hit_o
);

    logic [ways_p-1:0][idx_w_lp-1:0] stack_q;
    logic [ways_p-1:0][idx_w_lp-1:0] stack_mid;
    logic [ways_p-1:0][idx_w_lp-1:0] stack_nxt;
    logic [ways_p-1:0]               match2;
    logic [ways_p-1:0]               match1;
    logic [ways_p-1:0]               shift2;
    logic [ways_p-1:0]               shift1;

    // Event 2 moves first, then event 1 acts on the result so it ends as MRU.
    for (genvar g = 0; g < ways_p; g++) begin : g_shift
        assign match2[g] = (stack_q[g] == access2_i);
        assign match1[g] = (stack_mid[g] == access1_i);
        assign shift2[g] = v2_i & (|match2[g:0]);
        assign shift1[g] = v1_i & (|match1[g:0]);

        if (g == ways_p - 1) begin : g_top
            assign stack_mid[g] = shift2[g] ? access2_i : stack_q[g];
            assign stack_nxt[g] = shift1[g] ? access1_i : stack_mid[g];
        end else begin : g_body
            assign stack_mid[g] = shift2[g] ? stack_q[g+1]   : stack_q[g];
            assign stack_nxt[g] = shift1[g] ? stack_mid[g+1] : stack_mid[g];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < ways_p; k++) begin
                stack_q[k] <= idx_w_lp'(k);
            end
        end else begin
            stack_q <= stack_nxt;
        end
    end

    assign replace_which_o = stack_q[0];

    priority_encoder #(
        .width_p(ways_p)
    ) hit_encoder (
        .i   (hit_i),
        .o   (hit_idx_o),
        .v_o (any_hit_o)
    );

endmodule

// File: tb/tb_cache_lru_recorder.sv
// Directed self-checking bench for cache_lru_recorder.
module tb_cache_lru_recorder;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b0;
    logic [1:0] access1_i = '0;
    logic       v1_i = 1'b0;
    logic [1:0] access2_i = '0;
    logic       v2_i = 1'b0;
    logic [1:0] replace_which_o;
    logic [3:0] hit_i = '0;
    logic [1:0] hit_idx_o;
    logic       any_hit_o;

    int compared_count = 0;
    int mismatch_count = 0;

    cache_lru_recorder dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .access1_i       (access1_i),
        .v1_i            (v1_i),
        .access2_i       (access2_i),
        .v2_i            (v2_i),
        .replace_which_o (replace_which_o),
        .hit_i           (hit_i),
        .hit_idx_o       (hit_idx_o),
        .any_hit_o       (any_hit_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of touch events, then release them 1 ns after the edge.
    task automatic applyStimulus(input logic v1, input logic [1:0] a1,
                                 input logic v2, input logic [1:0] a2);
        v1_i      = v1;
        access1_i = a1;
        v2_i      = v2;
        access2_i = a2;
        @(posedge clk_i);
        #1;
        v1_i = 1'b0;
        v2_i = 1'b0;
    endtask

    task automatic doReset();
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    function automatic int stackValue();
        return int'(dut.stack_q);
    endfunction

    // Packed stack: entry 3 (MRU) in the top bits, entry 0 (LRU) in the bottom bits.
    initial begin
        $display("[TB] starting");
        @(posedge clk_i);
        #1;

        doReset();
        checkOutput("reset_victim", replace_which_o, 0);
        checkOutput("reset_stack", stackValue(), 8'hE4);
        applyStimulus(1'b1, 2'd2, 1'b0, 2'd0);
        checkOutput("touch2_victim", replace_which_o, 0);
        checkOutput("touch2_stack", stackValue(), 8'hB4);

        doReset();
        applyStimulus(1'b1, 2'd0, 1'b0, 2'd0);
        checkOutput("seq_t0_victim", replace_which_o, 1);
        applyStimulus(1'b1, 2'd1, 1'b0, 2'd0);
        checkOutput("seq_t1_victim", replace_which_o, 2);
        applyStimulus(1'b1, 2'd2, 1'b0, 2'd0);
        checkOutput("seq_t2_victim", replace_which_o, 3);
        applyStimulus(1'b1, 2'd3, 1'b0, 2'd0);
        checkOutput("seq_t3_victim", replace_which_o, 0);
        checkOutput("seq_stack", stackValue(), 8'hE4);
        applyStimulus(1'b0, 2'd2, 1'b0, 2'd1);
        checkOutput("idle_hold_stack", stackValue(), 8'hE4);

        doReset();
        applyStimulus(1'b1, 2'd1, 1'b1, 2'd0);
        checkOutput("dual_01_stack", stackValue(), 8'h4E);
        checkOutput("dual_01_victim", replace_which_o, 2);

        doReset();
        applyStimulus(1'b1, 2'd0, 1'b1, 2'd1);
        checkOutput("dual_10_stack", stackValue(), 8'h1E);
        checkOutput("dual_10_victim", replace_which_o, 2);

        doReset();
        applyStimulus(1'b1, 2'd3, 1'b1, 2'd3);
        checkOutput("dual_same_stack", stackValue(), 8'hE4);
        checkOutput("dual_same_victim", replace_which_o, 0);

        doReset();
        applyStimulus(1'b0, 2'd0, 1'b1, 2'd1);
        checkOutput("port2_only_stack", stackValue(), 8'h78);
        checkOutput("port2_only_victim", replace_which_o, 0);

        hit_i = 4'b1010;
        #1;
        checkOutput("enc_1010_idx", hit_idx_o, 1);
        checkOutput("enc_1010_any", any_hit_o, 1);
        hit_i = 4'b1000;
        #1;
        checkOutput("enc_1000_idx", hit_idx_o, 3);
        checkOutput("enc_1000_any", any_hit_o, 1);
        hit_i = 4'b1100;
        #1;
        checkOutput("enc_1100_idx", hit_idx_o, 2);
        hit_i = 4'b0111;
        #1;
        checkOutput("enc_0111_idx", hit_idx_o, 0);
        hit_i = 4'b0000;
        #1;
        checkOutput("enc_zero_idx", hit_idx_o, 0);
        checkOutput("enc_zero_any", any_hit_o, 0);

        doReset();
        applyStimulus(1'b1, 2'd0, 1'b0, 2'd0);
        applyStimulus(1'b1, 2'd1, 1'b0, 2'd0);
        checkOutput("pre_reset_victim", replace_which_o, 2);
        #2;
        reset_i   = 1'b1;
        v1_i      = 1'b1;
        access1_i = 2'd3;
        #1;
        checkOutput("async_reset_victim", replace_which_o, 0);
        @(posedge clk_i);
        #1;
        checkOutput("reset_touch_ignored", stackValue(), 8'hE4);
        reset_i = 1'b0;
        v1_i    = 1'b0;
        applyStimulus(1'b1, 2'd2, 1'b0, 2'd0);
        checkOutput("post_reset_stack", stackValue(), 8'hB4);
        checkOutput("post_reset_victim", replace_which_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_count, mismatch_count);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
